// File: rtl/lfsr_stream_gen.sv
// Parametrised LFSR stream generator: Fibonacci/Galois, OUT_BITS per handshake, lockup detect.
// Optional handshake period counter enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_stream_gen #(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      OUT_BITS     = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(16'h0001),
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(16'h002D)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed,
    input  logic [WIDTH-1:0]    taps,
    input  logic                mode,
    input  logic                en,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic [WIDTH-1:0]    state_o,
`ifdef LFSR_PERIOD_CNT_EN
    output logic                period_valid,
    output logic [WIDTH-1:0]    period_out,
`endif
    output logic                lockup
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LOCKED = 2'd2
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [WIDTH-1:0]    state_q, state_d;
    logic [WIDTH-1:0]    taps_q, taps_d;
    logic                mode_q, mode_d;
    logic [WIDTH-1:0]    step_state;
    logic [OUT_BITS-1:0] step_bits;
    logic                handshake;

    // OUT_BITS single steps unrolled; bit i is the bit emitted by step i.
    always_comb begin
        step_state = state_q;
        step_bits  = '0;
        for (int i = 0; i < int'(OUT_BITS); i++) begin
            step_bits[i] = step_state[0];
            if (mode_q) begin
                step_state = (step_state >> 1) ^ ({WIDTH{step_state[0]}} & taps_q);
            end else begin
                step_state = {^(step_state & taps_q), step_state[WIDTH-1:1]};
            end
        end
    end

    // State register and configuration capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= DEFAULT_SEED;
            taps_q  <= DEFAULT_TAPS;
            mode_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            taps_q  <= taps_d;
            mode_q  <= mode_d;
        end
    end

    // Next state; a load masks out_valid so a colliding beat is never seen as transferred.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        taps_d    = taps_q;
        mode_d    = mode_q;
        out_valid = 1'b0;
        lockup    = 1'b0;
        handshake = 1'b0;

        case (fsm_q)
            IDLE:    out_valid = 1'b0;
            RUN:     out_valid = en & ~load;
            LOCKED:  lockup    = 1'b1;
            default: fsm_d     = IDLE;
        endcase

        handshake = out_valid & out_ready;

        if (load) begin
            state_d = seed;
            taps_d  = taps;
            mode_d  = mode;
            fsm_d   = (seed == '0) ? LOCKED : RUN;
        end else if (handshake) begin
            state_d = step_state;
            fsm_d   = (step_state == '0) ? LOCKED : RUN;
        end
    end

    assign out_data = step_bits;
    assign state_o  = state_q;

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

    // Handshakes since load; reports the count whenever the state returns to the loaded seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q       <= DEFAULT_SEED;
            cnt_q        <= '0;
            period_valid <= 1'b0;
            period_out   <= '0;
        end else begin
            period_valid <= 1'b0;
            if (load) begin
                seed_q <= seed;
                cnt_q  <= '0;
            end else if (handshake) begin
                if (step_state == seed_q) begin
                    period_valid <= 1'b1;
                    period_out   <= cnt_inc;
                    cnt_q        <= '0;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Self-checking bench: two 5-bit instances (1 and 3 bits per beat) against a rule-level model.
module tb_lfsr_stream_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [4:0] seed = '0;
    logic [4:0] taps = '0;
    logic       mode = 1'b0;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;

    logic       v1, v3, lk1, lk3;
    logic [0:0] d1;
    logic [2:0] d3;
    logic [4:0] s1, s3;
`ifdef LFSR_PERIOD_CNT_EN
    logic       pv1, pv3;
    logic [4:0] po1, po3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_stream_gen #(.WIDTH(5), .OUT_BITS(1), .DEFAULT_SEED(5'h01), .DEFAULT_TAPS(5'h05)) u1 (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .taps(taps), .mode(mode),
        .en(en), .out_ready(out_ready), .out_valid(v1), .out_data(d1), .state_o(s1),
`ifdef LFSR_PERIOD_CNT_EN
        .period_valid(pv1), .period_out(po1),
`endif
        .lockup(lk1));

    lfsr_stream_gen #(.WIDTH(5), .OUT_BITS(3), .DEFAULT_SEED(5'h01), .DEFAULT_TAPS(5'h05)) u3 (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .taps(taps), .mode(mode),
        .en(en), .out_ready(out_ready), .out_valid(v3), .out_data(d3), .state_o(s3),
`ifdef LFSR_PERIOD_CNT_EN
        .period_valid(pv3), .period_out(po3),
`endif
        .lockup(lk3));

    // Reference model: index 0 is the 1-bit instance, index 1 the 3-bit instance.
    localparam int M_IDLE = 0, M_RUN = 1, M_LOCK = 2;
    logic [4:0] ms   [2];
    int         mst  [2];
    int         mcnt [2];
    logic       epv  [2];
    logic [4:0] epo  [2];
    int         nb   [2] = '{1, 3};
    logic [4:0] m_taps, m_seed;
    logic       m_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] step(input logic [4:0] s);
        if (m_mode) return (s >> 1) ^ (s[0] ? m_taps : 5'd0);
        return (s >> 1) | (5'(($countones(s & m_taps)) % 2) << 4);
    endfunction

    function automatic logic [4:0] adv(input logic [4:0] s, input int n);
        logic [4:0] r = s;
        for (int i = 0; i < n; i++) r = step(r);
        return r;
    endfunction

    function automatic logic [2:0] emit(input logic [4:0] s, input int n);
        logic [2:0] b = '0;
        logic [4:0] r = s;
        for (int i = 0; i < n; i++) begin
            b[i] = r[0];
            r = step(r);
        end
        return b;
    endfunction

    function automatic logic mvalid(input int k);
        return (mst[k] == M_RUN) && en && !load;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = 5'h01; mst[k] = M_IDLE; mcnt[k] = 0; epv[k] = 1'b0; epo[k] = '0;
        end
        m_taps = 5'h05; m_mode = 1'b0; m_seed = 5'h01;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state1"}, 32'(s1), 32'(ms[0]));
        chk({tag, ".state3"}, 32'(s3), 32'(ms[1]));
        chk({tag, ".valid1"}, 32'(v1), 32'(mvalid(0)));
        chk({tag, ".valid3"}, 32'(v3), 32'(mvalid(1)));
        chk({tag, ".lock1"}, 32'(lk1), 32'(mst[0] == M_LOCK));
        chk({tag, ".lock3"}, 32'(lk3), 32'(mst[1] == M_LOCK));
        chk({tag, ".data1"}, 32'(d1), 32'(emit(ms[0], 1)));
        chk({tag, ".data3"}, 32'(d3), 32'(emit(ms[1], 3)));
`ifdef LFSR_PERIOD_CNT_EN
        chk({tag, ".pv1"}, 32'(pv1), 32'(epv[0]));
        chk({tag, ".pv3"}, 32'(pv3), 32'(epv[1]));
        chk({tag, ".po1"}, 32'(po1), 32'(epo[0]));
        chk({tag, ".po3"}, 32'(po3), 32'(epo[1]));
`endif
    endtask

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic tick(input string tag);
        logic [4:0] nx;
        int inc;
        for (int k = 0; k < 2; k++) begin
            epv[k] = 1'b0;
            if (load) begin
                ms[k] = seed; mst[k] = (seed == 0) ? M_LOCK : M_RUN; mcnt[k] = 0;
            end else if (mvalid(k) && out_ready) begin
                nx = adv(ms[k], nb[k]);
                inc = (mcnt[k] == 31) ? 31 : mcnt[k] + 1;
                if (nx == m_seed) begin
                    epv[k] = 1'b1; epo[k] = 5'(inc); mcnt[k] = 0;
                end else begin
                    mcnt[k] = inc;
                end
                ms[k] = nx;
                if (nx == 0) mst[k] = M_LOCK;
            end
        end
        if (load) begin
            m_taps = taps; m_mode = mode; m_seed = seed;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input logic [4:0] s, input logic [4:0] t, input logic md, input string tag);
        load = 1'b1; seed = s; taps = t; mode = md;
        tick(tag);
        load = 1'b0;
    endtask

    logic [0:0] exp_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        model_reset();
        reset = 1'b1;
        #12;
        check_all("reset");
        chk("reset.state_default", 32'(s1), 32'h01);
        @(negedge clk);
        reset = 1'b0;

        // IDLE holds even with en/ready high.
        en = 1'b1; out_ready = 1'b1;
        repeat (3) tick("idle");

        // Fibonacci 5-bit reference sequence.
        do_load(5'b00001, 5'b00101, 1'b0, "load_fib");
        chk("fib3.first", 32'(d3), 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk("fib1.seq", 32'(d1), 32'(exp_seq[i]));
            if (i < 5) tick("fib_run");
            if (i == 4) chk("fib1.state5", 32'(s1), 32'h09);
        end

        // Backpressure: everything frozen while out_ready is low.
        out_ready = 1'b0;
        repeat (4) tick("stall");
        chk("stall.valid", 32'(v1), 32'h1);
        out_ready = 1'b1;
        repeat (3) tick("resume");

        // Full period in Fibonacci and Galois modes.
        do_load(5'b00001, 5'b00101, 1'b0, "per_fib");
        repeat (31) tick("per_fib_run");
`ifdef LFSR_PERIOD_CNT_EN
        chk("per_fib.pv", 32'(pv1), 32'h1);
        chk("per_fib.po", 32'(po1), 32'd31);
`endif
        repeat (4) tick("per_fib_more");
        do_load(5'b00001, 5'b10100, 1'b1, "per_gal");
        repeat (31) tick("per_gal_run");
`ifdef LFSR_PERIOD_CNT_EN
        chk("per_gal.pv", 32'(pv1), 32'h1);
        chk("per_gal.po", 32'(po1), 32'd31);
`endif
        repeat (40) tick("per_gal_more");

        // Drain to zero with degenerate taps, then recover, then load a zero seed.
        do_load(5'b00001, 5'b00100, 1'b0, "drain");
        tick("drain_step");
        chk("drain.state", 32'(s1), 32'h0);
        chk("drain.lockup", 32'(lk1), 32'h1);
        chk("drain.valid", 32'(v1), 32'h0);
        repeat (2) tick("locked_hold");
        do_load(5'b00011, 5'b00101, 1'b0, "recover");
        chk("recover.lockup", 32'(lk1), 32'h0);
        tick("recover_run");
        do_load(5'b00000, 5'b00101, 1'b0, "zero_seed");
        chk("zero_seed.lockup", 32'(lk1), 32'h1);
        do_load(5'b00001, 5'b00000, 1'b1, "taps0_gal");
        repeat (6) tick("taps0_run");

        // Load colliding with a handshake: new seed, no advance.
        do_load(5'b00001, 5'b00101, 1'b0, "pre_collide");
        repeat (2) tick("collide_run");
        do_load(5'b10110, 5'b00101, 1'b0, "collide");
        chk("collide.state1", 32'(s1), 32'h16);
        chk("collide.state3", 32'(s3), 32'h16);

        // Randomised traffic with occasional reloads.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 15) == 0);
            seed = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            taps = 5'($urandom);
            mode = 1'($urandom);
            tick("rand");
        end
        load = 1'b0;

        // Asynchronous reset mid-run.
        do_load(5'b00111, 5'b00101, 1'b0, "pre_reset");
        en = 1'b1; out_ready = 1'b1;
        repeat (3) tick("pre_reset_run");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("midreset");
        chk("midreset.state", 32'(s1), 32'h01);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick("after_reset");
        chk("after_reset.valid", 32'(v1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
